string_receiver: RTL and testbench
==================================

# string_receiver

Serial LED-protocol decoder, the receive end of the string driver link. Samples one single-wire LED data line and measures high-pulse widths to recover bits. Assembles 24-bit pixels MSB-first and packs them into 16-bit words for a pixel FIFO, using the same byte order the transmit path consumes. Used for loopback verification of the string outputs and for capturing the DOUT of the last LED in a string.

## Interface
- CLK_PERIOD_NS, 50, clk period; all timing derived as ns/CLK_PERIOD_NS (integer division)
- T_MIN_HIGH_NS, 150, shorter high pulse = glitch error (3 cycles)
- T_THRESH_NS, 600, high width >= threshold decodes 1, else 0 (12 cycles)
- T_MAX_HIGH_NS, 1200, longer high pulse = error (24 cycles)
- T_RESET_NS, 50000, low time that ends a frame (1000 cycles)
- MAX_PIXELS, 1024, sizes frame_pixels

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sdi  in  1  LED data line, asynchronous to clk
- fifo_full  in  1  downstream FIFO cannot accept a word
- fifo_wr_data  out  16  packed pixel word
- fifo_wr_en  out  1  one-cycle write strobe
- frame_active  out  1  high from first rising edge of a frame until frame end
- frame_done  out  1  one-cycle pulse at frame end
- frame_pixels  out  $clog2(MAX_PIXELS+1)  complete pixels decoded in the last frame; valid with frame_done, held until the next frame_done
- bit_error  out  1  sticky: glitch, over-long pulse, or partial pixel at frame end
- overflow  out  1  sticky: a word was dropped because fifo_full was high

## Operation
- sdi passes through a 2-flop synchronizer; edges are detected on the synchronized value.
- States:
  - S_UNSYNC: after reset. Waits for the line to stay low for RESET_CYCLES, then goes to S_IDLE. A high resets the wait counter.
  - S_IDLE: on a rising edge, clears bit_error and overflow, zeroes the bit and pixel counters, raises frame_active, then goes to S_HIGH.
  - S_HIGH: counts high cycles, saturating at MAX_HIGH+1. On a falling edge, classifies the pulse:
    - width < MIN or > MAX: sets bit_error and discards the partial pixel.
    - otherwise: shifts the bit (0 or 1 per threshold) into the pixel register.
    - Goes to S_LOW in both cases.
  - S_LOW: counts low cycles.
    - Rising edge: go to S_HIGH.
    - Count reaches RESET_CYCLES: frame end. Go to S_IDLE, pulse frame_done, drop frame_active.
- Pixel assembly: the 24th valid bit completes a pixel and increments the pixel count. frame_pixels saturates at MAX_PIXELS.
- Packing (p0, p1 = consecutive pixels):
  - w0 = p0[15:0]
  - w1 = {p1[7:0], p0[23:16]}
  - w2 = p1[23:8]
  - w0 is written when p0 completes; w1 and w2 are written when p1 completes, on consecutive cycles.
- Frame end:
  - Odd pixel count: writes pad word {8'h00, p0[23:16]} in the frame_done cycle.
  - Nonzero bit count: sets bit_error and discards the partial bits.
- Backpressure: any word offered while fifo_full is high is dropped and sets overflow. There is no stall and no retry.
- Reset mid-frame: all state clears and the block enters S_UNSYNC. The remainder of that frame is ignored.

## Timing
- Reset values: fifo_wr_en 0, fifo_wr_data 0, frame_active 0, frame_done 0, frame_pixels 0, bit_error 0, overflow 0. State is S_UNSYNC.
- Edge 0 = first clk edge sampling sdi low at the pin. The write for a completing bit asserts fifo_wr_en in the cycle after edge 3 (sync 2, edge detect 1, word register 1).
- frame_done asserts RESET_CYCLES+2 cycles after the last falling edge at the pin.
- fifo_wr_en never exceeds 2 consecutive cycles except for the pad word, which can follow at the earliest 1000 cycles later.
- Pulse width measured in synchronized cycles. Jitter of ±1 cycle at the threshold is acceptable.

## Configuration
- STRING_RECEIVER_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchronizer. It rejects single-cycle spikes and adds 1 cycle to all latencies (write in the cycle after edge 4).
- Undefined: the synchronized value feeds edge detection directly, and a 1-cycle spike registers as a glitch error.

## Structure
- Package string_pkg holds:
  - default timing constants (ns)
  - a function converting ns to cycles
  - the state enum (S_UNSYNC, S_IDLE, S_HIGH, S_LOW)
  - the FIFO word width
- Sub-module pixel_word_packer takes a 24-bit pixel stream, a flush request and fifo_full. It emits the 3-words-per-2-pixels sequence plus the pad word and reports drops.

## Test plan
- Reset, line low 50 us, then 2 pixels 0xFF0000 and 0x00FF01 (8/16-cycle highs, 25-cycle bits), then 50 us low -> writes 0x0000, 0x01FF, 0x00FF; frame_pixels=2; no flags.
- 3 pixels 0x123456, 0xABCDEF, 0x0F0F0F -> writes 0x3456, 0xEF12, 0xABCD, 0x0F0F, 0x000F (pad in the frame_done cycle); frame_pixels=3.
- 2-cycle high pulse mid-pixel -> bit_error=1, pixel discarded. bit_error clears at the next frame's first rising edge.
- fifo_full held high during w1/w2 of a pixel pair -> both dropped, overflow=1, w0 written.
- 30 bits, then 50 us low -> 1 pixel and a pad word written, bit_error=1. Reset_n low mid-frame -> no further writes until 50 us of low.
- With STRING_RECEIVER_GLITCH_FILTER_EN: 1-cycle spike during a low period -> no error, no bit; write latency is one cycle longer.

Source files
------------

// File: rtl/string_pkg.sv
// -----------------------------------------------------------------------------
// string_pkg
// Shared definitions for the LED string receive path:
//   - default pulse timing constants in nanoseconds
//   - ns2cyc(): converts a duration in ns to whole clock cycles
//   - state_t : receiver FSM states
//   - WORD_W / PIX_W : FIFO word width and pixel width
// -----------------------------------------------------------------------------
package string_pkg;

   localparam int CLK_PERIOD_NS_DEF = 50;
   localparam int T_MIN_HIGH_NS_DEF = 150;
   localparam int T_THRESH_NS_DEF   = 600;
   localparam int T_MAX_HIGH_NS_DEF = 1200;
   localparam int T_RESET_NS_DEF    = 50000;
   localparam int MAX_PIXELS_DEF    = 1024;

   localparam int WORD_W = 16;
   localparam int PIX_W  = 24;

   typedef enum logic [1:0] {
      S_UNSYNC,
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   // Integer division: partial cycles are dropped.
   function automatic int ns2cyc(input int ns, input int period_ns);
      return ns / period_ns;
   endfunction

endpackage

// File: rtl/string_receiver_packer.sv
// -----------------------------------------------------------------------------
// pixel_word_packer
// Packs a stream of 24-bit pixels into 16-bit FIFO words, three words per
// pixel pair:  w0 = p0[15:0], w1 = {p1[7:0], p0[23:16]}, w2 = p1[23:8].
// A flush with an unpaired pixel emits the pad word {8'h00, p0[23:16]}.
// Words offered while fifo_full is high are dropped (no retry).
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   pix_vld, pix    one-cycle pixel strobe and 24-bit pixel
//   flush           end of frame; emits pad word if a pixel is unpaired
//   fifo_full       downstream cannot accept a word
//   wr_data, wr_en  FIFO write port
//   drop            a word was offered while fifo_full was high
// -----------------------------------------------------------------------------
module pixel_word_packer
   import string_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pix_vld,
   input  logic [PIX_W-1:0]  pix,
   input  logic              flush,
   input  logic              fifo_full,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_en,
   output logic              drop
);

   logic              phase_q, phase_d;       // 1: holding the upper byte of p0
   logic [7:0]        p0_hi_q, p0_hi_d;
   logic              w2_pend_q, w2_pend_d;
   logic [WORD_W-1:0] w2_q, w2_d;
   logic              offer_q, offer_d;
   logic [WORD_W-1:0] word_q, word_d;

   always_comb begin
      phase_d   = phase_q;
      p0_hi_d   = p0_hi_q;
      w2_pend_d = 1'b0;
      w2_d      = w2_q;
      offer_d   = 1'b0;
      word_d    = word_q;
      // Pixels arrive at most once every 24 bit periods, so w2 never collides
      // with a new pixel or a flush.
      if (w2_pend_q) begin
         offer_d = 1'b1;
         word_d  = w2_q;
      end else if (pix_vld) begin
         offer_d = 1'b1;
         if (!phase_q) begin
            word_d  = pix[15:0];
            p0_hi_d = pix[23:16];
            phase_d = 1'b1;
         end else begin
            word_d    = {pix[7:0], p0_hi_q};
            w2_d      = pix[23:8];
            w2_pend_d = 1'b1;
            phase_d   = 1'b0;
         end
      end else if (flush) begin
         if (phase_q) begin
            offer_d = 1'b1;
            word_d  = {8'h00, p0_hi_q};
         end
         phase_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q   <= 1'b0;
         p0_hi_q   <= '0;
         w2_pend_q <= 1'b0;
         w2_q      <= '0;
         offer_q   <= 1'b0;
         word_q    <= '0;
      end else begin
         phase_q   <= phase_d;
         p0_hi_q   <= p0_hi_d;
         w2_pend_q <= w2_pend_d;
         w2_q      <= w2_d;
         offer_q   <= offer_d;
         word_q    <= word_d;
      end
   end

   // fifo_full is judged in the cycle the word is presented.
   assign wr_data = word_q;
   assign wr_en   = offer_q & ~fifo_full;
   assign drop    = offer_q & fifo_full;

endmodule

// File: rtl/string_receiver.sv
// -----------------------------------------------------------------------------
// string_receiver
// Receive end of the single-wire LED link. Synchronises sdi, measures high
// pulse widths to recover bits, assembles 24-bit pixels MSB-first and hands
// them to pixel_word_packer for the pixel FIFO.
//
// Optional feature macro: STRING_RECEIVER_GLITCH_FILTER_EN
//   defined   : 3-sample majority filter after the synchroniser (+1 cycle)
//   undefined : synchronised sdi feeds edge detection directly
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   sdi            LED data line (asynchronous)
//   fifo_full      downstream FIFO cannot accept a word
//   fifo_wr_data   packed pixel word
//   fifo_wr_en     one-cycle write strobe
//   frame_active   first rising edge of a frame until frame end
//   frame_done     one-cycle pulse at frame end
//   frame_pixels   complete pixels of last frame, updated with frame_done
//   bit_error      sticky: glitch, over-long pulse, partial pixel at end
//   overflow       sticky: a word was dropped on fifo_full
// -----------------------------------------------------------------------------
module string_receiver
   import string_pkg::*;
#(
   parameter int CLK_PERIOD_NS = CLK_PERIOD_NS_DEF,
   parameter int T_MIN_HIGH_NS = T_MIN_HIGH_NS_DEF,
   parameter int T_THRESH_NS   = T_THRESH_NS_DEF,
   parameter int T_MAX_HIGH_NS = T_MAX_HIGH_NS_DEF,
   parameter int T_RESET_NS    = T_RESET_NS_DEF,
   parameter int MAX_PIXELS    = MAX_PIXELS_DEF
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              sdi,
   input  logic                              fifo_full,
   output logic [WORD_W-1:0]                 fifo_wr_data,
   output logic                              fifo_wr_en,
   output logic                              frame_active,
   output logic                              frame_done,
   output logic [$clog2(MAX_PIXELS+1)-1:0]   frame_pixels,
   output logic                              bit_error,
   output logic                              overflow
);

   localparam int MIN_HIGH     = ns2cyc(T_MIN_HIGH_NS, CLK_PERIOD_NS);
   localparam int THRESH       = ns2cyc(T_THRESH_NS, CLK_PERIOD_NS);
   localparam int MAX_HIGH     = ns2cyc(T_MAX_HIGH_NS, CLK_PERIOD_NS);
   localparam int RESET_CYCLES = ns2cyc(T_RESET_NS, CLK_PERIOD_NS);
   localparam int HCNT_W       = $clog2(MAX_HIGH + 2);
   localparam int LCNT_W       = $clog2(RESET_CYCLES + 1);
   localparam int PCNT_W       = $clog2(MAX_PIXELS + 1);

   localparam logic [HCNT_W-1:0] MIN_H  = HCNT_W'(MIN_HIGH);
   localparam logic [HCNT_W-1:0] THR_H  = HCNT_W'(THRESH);
   localparam logic [HCNT_W-1:0] MAX_H  = HCNT_W'(MAX_HIGH);
   localparam logic [HCNT_W-1:0] SAT_H  = HCNT_W'(MAX_HIGH + 1);
   localparam logic [LCNT_W-1:0] RST_M1 = LCNT_W'(RESET_CYCLES - 1);
   localparam logic [PCNT_W-1:0] PIX_SAT = PCNT_W'(MAX_PIXELS);

   // ---- input synchroniser and optional majority filter ----
   logic sdi_s1_q, sdi_s2_q, line, line_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sdi_s1_q <= 1'b0;
         sdi_s2_q <= 1'b0;
      end else begin
         sdi_s1_q <= sdi;
         sdi_s2_q <= sdi_s1_q;
      end
   end

`ifdef STRING_RECEIVER_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hist_q <= '0;
      else          hist_q <= {hist_q[0], sdi_s2_q};
   end
   // Majority of the current and two previous samples: one cycle of delay,
   // single-cycle spikes in either direction are removed.
   assign line = (sdi_s2_q & hist_q[0]) | (sdi_s2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign line = sdi_s2_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) line_prev_q <= 1'b0;
      else          line_prev_q <= line;
   end

   logic rise, fall;
   assign rise = line & ~line_prev_q;
   assign fall = ~line & line_prev_q;

   // ---- FSM and bit/pixel datapath ----
   state_t              state_q, state_d;
   logic [HCNT_W-1:0]   high_cnt_q, high_cnt_d;
   logic [LCNT_W-1:0]   low_cnt_q, low_cnt_d;
   logic [4:0]          bit_cnt_q, bit_cnt_d;
   logic [PIX_W-2:0]    pix_sr_q, pix_sr_d;
   logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic                pix_vld_q, pix_vld_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic                flush_q, flush_d;
   logic                active_q, active_d;
   logic                done_q, done_d;
   logic [PCNT_W-1:0]   fpix_q, fpix_d;
   logic                err_q, err_d;
   logic                ovf_q, ovf_d;
   logic                bit_val, low_done, pk_drop;

   assign low_done = (low_cnt_q == RST_M1);
   assign bit_val  = (high_cnt_q >= THR_H);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_UNSYNC;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_UNSYNC: if (!line && low_done) state_d = S_IDLE;
         S_IDLE:   if (rise)              state_d = S_HIGH;
         S_HIGH:   if (fall)              state_d = S_LOW;
         S_LOW: begin
            if (rise)          state_d = S_HIGH;
            else if (low_done) state_d = S_IDLE;
         end
         default:                         state_d = S_UNSYNC;
      endcase
   end

   always_comb begin
      high_cnt_d = high_cnt_q;
      low_cnt_d  = low_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      pix_sr_d   = pix_sr_q;
      pix_cnt_d  = pix_cnt_q;
      pix_vld_d  = 1'b0;
      pix_d      = pix_q;
      flush_d    = 1'b0;
      active_d   = active_q;
      err_d      = err_q;
      ovf_d      = ovf_q | pk_drop;
      // Frame results land one cycle after flush, aligned with the pad word.
      done_d     = flush_q;
      fpix_d     = flush_q ? pix_cnt_q : fpix_q;
      if (flush_q) active_d = 1'b0;

      case (state_q)
         S_UNSYNC: low_cnt_d = line ? '0 : low_cnt_q + 1'b1;
         S_IDLE: begin
            if (rise) begin
               err_d      = 1'b0;
               ovf_d      = 1'b0;
               bit_cnt_d  = '0;
               pix_cnt_d  = '0;
               active_d   = 1'b1;
               high_cnt_d = 1;
            end
         end
         S_HIGH: begin
            if (fall) begin
               low_cnt_d = 1;
               if (high_cnt_q < MIN_H || high_cnt_q > MAX_H) begin
                  err_d     = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  pix_sr_d = {pix_sr_q[PIX_W-3:0], bit_val};
                  if (bit_cnt_q == 5'd23) begin
                     pix_vld_d = 1'b1;
                     pix_d     = {pix_sr_q, bit_val};
                     bit_cnt_d = '0;
                     if (pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end else if (high_cnt_q != SAT_H) begin
               high_cnt_d = high_cnt_q + 1'b1;
            end
         end
         S_LOW: begin
            if (rise) begin
               high_cnt_d = 1;
            end else if (low_done) begin
               flush_d = 1'b1;
               if (bit_cnt_q != '0) err_d = 1'b1;
               bit_cnt_d = '0;
            end else begin
               low_cnt_d = low_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         high_cnt_q <= '0;
         low_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         pix_sr_q   <= '0;
         pix_cnt_q  <= '0;
         pix_vld_q  <= 1'b0;
         pix_q      <= '0;
         flush_q    <= 1'b0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         fpix_q     <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         high_cnt_q <= high_cnt_d;
         low_cnt_q  <= low_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         pix_sr_q   <= pix_sr_d;
         pix_cnt_q  <= pix_cnt_d;
         pix_vld_q  <= pix_vld_d;
         pix_q      <= pix_d;
         flush_q    <= flush_d;
         active_q   <= active_d;
         done_q     <= done_d;
         fpix_q     <= fpix_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
      end
   end

   pixel_word_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .pix_vld   (pix_vld_q),
      .pix       (pix_q),
      .flush     (flush_q),
      .fifo_full (fifo_full),
      .wr_data   (fifo_wr_data),
      .wr_en     (fifo_wr_en),
      .drop      (pk_drop)
   );

   assign frame_active = active_q;
   assign frame_done   = done_q;
   assign frame_pixels = fpix_q;
   assign bit_error    = err_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_string_receiver.sv
// Directed bench for string_receiver: bit-level sdi waveforms, a write monitor
// and hand-computed expected FIFO words and flags.
module tb_string_receiver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sdi;
   logic        fifo_full;
   logic [15:0] fifo_wr_data;
   logic        fifo_wr_en;
   logic        frame_active;
   logic        frame_done;
   logic [10:0] frame_pixels;
   logic        bit_error;
   logic        overflow;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   logic [15:0] words[$];
   logic        pad_done;
   int          lat;

`ifdef STRING_RECEIVER_GLITCH_FILTER_EN
   localparam int          LAT_EXP   = 6;
   localparam logic [31:0] SPIKE_ERR = 0;
`else
   localparam int          LAT_EXP   = 5;
   localparam logic [31:0] SPIKE_ERR = 1;
`endif

   string_receiver dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sdi          (sdi),
      .fifo_full    (fifo_full),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .frame_active (frame_active),
      .frame_done   (frame_done),
      .frame_pixels (frame_pixels),
      .bit_error    (bit_error),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (fifo_wr_en === 1'b1) begin
         words.push_back(fifo_wr_data);
         if (frame_done === 1'b1) pad_done = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // 25-cycle bit: 16 high for a one, 8 high for a zero.
   task automatic send_bit(input logic b);
      sdi = 1'b1;
      cyc(b ? 16 : 8);
      sdi = 1'b0;
      cyc(b ? 9 : 17);
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic start_frame();
      words.delete();
      pad_done = 1'b0;
   endtask

   task automatic end_frame();
      logic got;
      got = 1'b0;
      sdi = 1'b0;
      for (int i = 0; i < 1300 && !got; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) got = 1'b1;
      end
      chk("frame_done_seen", got, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [15:0] exp);
      if (idx < words.size()) chk(tag, words[idx], exp);
      else                    chk({tag, "_missing"}, 32'hDEAD0000, exp);
   endtask

   initial begin
      reset_n   = 1'b0;
      sdi       = 1'b0;
      fifo_full = 1'b0;
      pad_done  = 1'b0;
      cyc(4);
      chk("rst_wr_en",   fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_active",  frame_active, 0);
      chk("rst_done",    frame_done, 0);
      chk("rst_pixels",  frame_pixels, 0);
      chk("rst_bit_err", bit_error, 0);
      chk("rst_ovf",     overflow, 0);
      reset_n = 1'b1;
      cyc(1010);

      // Frame 1: 0xFF0000, 0x00FF01, with write latency on the first pixel.
      start_frame();
      send_bits(24'h7F8000, 23);
      chk("f1_active", frame_active, 1);
      sdi = 1'b1;
      cyc(8);
      sdi = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (fifo_wr_en === 1'b1 && lat == 0) lat = i;
      end
      @(posedge clk);
      #1;
      cyc(7);
      chk("f1_wr_latency", lat, LAT_EXP);
      send_bits(24'h00FF01, 24);
      end_frame();
      chk("f1_nwords", words.size(), 3);
      chk_word("f1_w0", 0, 16'h0000);
      chk_word("f1_w1", 1, 16'h01FF);
      chk_word("f1_w2", 2, 16'h00FF);
      chk("f1_pixels", frame_pixels, 2);
      chk("f1_bit_err", bit_error, 0);
      chk("f1_ovf", overflow, 0);
      chk("f1_no_pad", pad_done, 0);
      chk("f1_active_end", frame_active, 0);

      // Frame 2: three pixels, pad word in the frame_done cycle.
      start_frame();
      send_bits(24'h123456, 24);
      send_bits(24'hABCDEF, 24);
      send_bits(24'h0F0F0F, 24);
      end_frame();
      chk("f2_nwords", words.size(), 5);
      chk_word("f2_w0", 0, 16'h3456);
      chk_word("f2_w1", 1, 16'hEF12);
      chk_word("f2_w2", 2, 16'hABCD);
      chk_word("f2_w3", 3, 16'h0F0F);
      chk_word("f2_pad", 4, 16'h000F);
      chk("f2_pad_with_done", pad_done, 1);
      chk("f2_pixels", frame_pixels, 3);
      chk("f2_bit_err", bit_error, 0);

      // Frame 3: 2-cycle glitch after 10 bits discards them.
      start_frame();
      send_bits(24'h0003FF, 10);
      sdi = 1'b1;
      cyc(2);
      sdi = 1'b0;
      cyc(23);
      send_bits(24'h00AA55, 24);
      end_frame();
      chk("f3_nwords", words.size(), 2);
      chk_word("f3_w0", 0, 16'hAA55);
      chk_word("f3_pad", 1, 16'h0000);
      chk("f3_bit_err", bit_error, 1);
      chk("f3_pixels", frame_pixels, 1);

      // Frame 4: fifo_full across the second pixel drops w1 and w2.
      start_frame();
      send_bit(1'b0);
      chk("f4_err_cleared", bit_error, 0);
      send_bits(24'h111111, 23);
      fifo_full = 1'b1;
      send_bits(24'h222222, 24);
      fifo_full = 1'b0;
      end_frame();
      chk("f4_nwords", words.size(), 1);
      chk_word("f4_w0", 0, 16'h1111);
      chk("f4_ovf", overflow, 1);
      chk("f4_pixels", frame_pixels, 2);
      chk("f4_bit_err", bit_error, 0);

      // Frame 5: 30 bits -> one pixel, pad, partial-pixel error.
      start_frame();
      send_bits(24'h0A0B0C, 24);
      send_bits(24'h00002A, 6);
      end_frame();
      chk("f5_nwords", words.size(), 2);
      chk_word("f5_w0", 0, 16'h0B0C);
      chk_word("f5_pad", 1, 16'h000A);
      chk("f5_bit_err", bit_error, 1);
      chk("f5_ovf_cleared", overflow, 0);
      chk("f5_pixels", frame_pixels, 1);

      // Frame 6: reset mid-frame, then traffic ignored until the line idles.
      start_frame();
      send_bits(24'h000FFF, 12);
      chk("f6_active", frame_active, 1);
      reset_n = 1'b0;
      sdi     = 1'b0;
      cyc(3);
      chk("f6_rst_active", frame_active, 0);
      chk("f6_rst_pixels", frame_pixels, 0);
      reset_n = 1'b1;
      start_frame();
      send_bits(24'h5A5A5A, 24);
      cyc(20);
      chk("f6_no_write_unsync", words.size(), 0);
      chk("f6_unsync_inactive", frame_active, 0);
      cyc(1010);
      start_frame();
      send_bits(24'h00C0DE, 24);
      end_frame();
      chk("f6_nwords", words.size(), 2);
      chk_word("f6_w0", 0, 16'hC0DE);
      chk_word("f6_pad", 1, 16'h0000);
      chk("f6_pixels", frame_pixels, 1);

      // Frame 7: single-cycle spike between pixels.
      start_frame();
      send_bits(24'h345678, 24);
      cyc(5);
      sdi = 1'b1;
      cyc(1);
      sdi = 1'b0;
      cyc(10);
      send_bits(24'h9ABCDE, 24);
      end_frame();
      chk("f7_nwords", words.size(), 3);
      chk_word("f7_w0", 0, 16'h5678);
      chk_word("f7_w1", 1, 16'hDE34);
      chk_word("f7_w2", 2, 16'h9ABC);
      chk("f7_pixels", frame_pixels, 2);
      chk("f7_spike_err", bit_error, SPIKE_ERR);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
